// File: rtl/balance_cntrl_slew.sv
// Pipelined balance controller: PID pitch loop, soft-start scaling, steering mix,
// per-update slew limiting of both motor commands and hysteretic too_fast flag.
module balance_cntrl_slew #(
  parameter bit FAST_SIM = 1'b1,
  parameter int SPD_W    = 12,
  parameter int P_COEF   = 9,
  parameter int SLEW     = 64,
  parameter int TF_HI    = 1536,
  parameter int TF_LO    = 1280
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld,
  input  logic signed [15:0]      ptch,
  input  logic signed [15:0]      ptch_rt,
  input  logic                    pwr_up,
  input  logic                    rider_off,
  input  logic        [11:0]      steer_pot,
  input  logic                    en_steer,
  output logic signed [SPD_W-1:0] lft_spd,
  output logic signed [SPD_W-1:0] rght_spd,
  output logic                    spd_vld,
  output logic                    too_fast,
  output logic        [7:0]       ss_tmr
);

  localparam int                     SMAX    = 2**(SPD_W-1) - 1;
  localparam logic            [23:0] SS_INC  = FAST_SIM ? 24'h010000 : 24'h000001;
  localparam logic signed     [15:0] P_C     = 16'(P_COEF);
  localparam logic signed     [27:0] SUM_MAX = 28'(SMAX);
  localparam logic signed [SPD_W+1:0] TGT_MAX = (SPD_W+2)'(SMAX);
  localparam logic signed   [SPD_W:0] SLEW_W  = (SPD_W+1)'(SLEW);
  localparam logic signed [SPD_W-1:0] SLEW_S  = SPD_W'(SLEW);
  localparam logic          [SPD_W:0] TF_HI_W = (SPD_W+1)'(TF_HI);
  localparam logic          [SPD_W:0] TF_LO_W = (SPD_W+1)'(TF_LO);

  // State
  logic        [23:0]      cnt_q, cnt_d;
  logic signed [17:0]      integ_q, integ_d;
  logic                    v1_q, v2_q, pwr_up_q;
  logic signed [25:0]      p_q, p_d;
  logic signed [11:0]      i_q, i_d, d_q, d_d;
  logic signed [SPD_W-1:0] tgt_l_q, tgt_r_q, tgt_l_d, tgt_r_d;
  logic signed [SPD_W-1:0] lft_q, rght_q;
  logic                    spd_vld_q, tf_q, tf_d;

  // Combinational intermediates
  logic signed [9:0]       err;
  logic signed [18:0]      integ_sum;
  logic signed [27:0]      sum;
  logic signed [SPD_W-1:0] pid, pid_ss;
  logic signed [SPD_W+8:0] prod;
  logic        [11:0]      pot_clip;
  logic signed [12:0]      st_diff;
  logic signed [14:0]      st_x3;
  logic signed [10:0]      steer;
  logic signed [SPD_W+1:0] l_sum, r_sum;

  function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [SPD_W+1:0] x);
    if (x > TGT_MAX)       return SPD_W'(TGT_MAX);
    else if (x < -TGT_MAX) return SPD_W'(-TGT_MAX);
    else                   return x[SPD_W-1:0];
  endfunction

  // Step toward the target by at most SLEW; difference taken one bit wider so it never wraps.
  function automatic logic signed [SPD_W-1:0] slew_step(input logic signed [SPD_W-1:0] cur,
                                                        input logic signed [SPD_W-1:0] tgt);
    logic signed [SPD_W:0] diff;
    diff = (SPD_W+1)'(tgt) - (SPD_W+1)'(cur);
    if (diff > SLEW_W)       return cur + SLEW_S;
    else if (diff < -SLEW_W) return cur - SLEW_S;
    else                     return tgt;
  endfunction

  function automatic logic [SPD_W:0] mag(input logic signed [SPD_W-1:0] x);
    logic signed [SPD_W:0] w;
    w = (SPD_W+1)'(x);
    return (w < 0) ? $unsigned(-w) : $unsigned(w);
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    if (!pwr_up)                         cnt_d = '0;
    else if (cnt_q > 24'hFFFFFF - SS_INC) cnt_d = 24'hFFFFFF;
    else                                 cnt_d = cnt_q + SS_INC;

    if (ptch > 16'sd511)       err = 10'sd511;
    else if (ptch < -16'sd511) err = -10'sd511;
    else                       err = ptch[9:0];

    integ_sum = 19'(integ_q) + 19'(err);
    if (rider_off)                      integ_d = '0;
    else if (integ_sum > 19'sd131071)   integ_d = 18'sd131071;
    else if (integ_sum < -19'sd131071)  integ_d = -18'sd131071;
    else                                integ_d = integ_sum[17:0];

    p_d = 26'(err) * 26'(P_C);
    i_d = 12'(integ_d >>> 6);
    d_d = -(12'(ptch_rt >>> 6));

    sum = 28'(p_q) + 28'(i_q) + 28'(d_q);
    if (sum > SUM_MAX)       pid = SPD_W'(SUM_MAX);
    else if (sum < -SUM_MAX) pid = SPD_W'(-SUM_MAX);
    else                     pid = sum[SPD_W-1:0];

    // Soft-start scale never grows the magnitude, so truncating back to SPD_W is lossless.
    prod   = (SPD_W+9)'(pid) * (SPD_W+9)'($signed({1'b0, cnt_q[23:16]}));
    pid_ss = SPD_W'(prod >>> 8);

    if (steer_pot < 12'h200)      pot_clip = 12'h200;
    else if (steer_pot > 12'hE00) pot_clip = 12'hE00;
    else                          pot_clip = steer_pot;
    st_diff = $signed({1'b0, pot_clip}) - 13'sd2047;
    st_x3   = 15'(st_diff) * 15'sd3;
    steer   = en_steer ? 11'(st_x3 >>> 4) : '0;

    l_sum   = (SPD_W+2)'(pid_ss) + (SPD_W+2)'(steer);
    r_sum   = (SPD_W+2)'(pid_ss) - (SPD_W+2)'(steer);
    tgt_l_d = sat_spd(l_sum);
    tgt_r_d = sat_spd(r_sum);

    if ((mag(lft_q) > TF_HI_W) || (mag(rght_q) > TF_HI_W))        tf_d = 1'b1;
    else if ((mag(lft_q) <= TF_LO_W) && (mag(rght_q) <= TF_LO_W)) tf_d = 1'b0;
    else                                                          tf_d = tf_q;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      integ_q   <= '0;
      pwr_up_q  <= 1'b0;
      v1_q      <= 1'b0;
      p_q       <= '0;
      i_q       <= '0;
      d_q       <= '0;
      v2_q      <= 1'b0;
      tgt_l_q   <= '0;
      tgt_r_q   <= '0;
      lft_q     <= '0;
      rght_q    <= '0;
      spd_vld_q <= 1'b0;
      tf_q      <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pwr_up_q <= pwr_up;
      if (!pwr_up) begin
        // Forced shutdown bypasses the slew limiter; one strobe announces the zeroed speeds.
        integ_q   <= '0;
        v1_q      <= 1'b0;
        p_q       <= '0;
        i_q       <= '0;
        d_q       <= '0;
        v2_q      <= 1'b0;
        tgt_l_q   <= '0;
        tgt_r_q   <= '0;
        lft_q     <= '0;
        rght_q    <= '0;
        spd_vld_q <= pwr_up_q;
        tf_q      <= 1'b0;
      end else begin
        if (rider_off || vld) integ_q <= integ_d;
        v1_q <= vld;
        if (vld) begin
          p_q <= p_d;
          i_q <= i_d;
          d_q <= d_d;
        end
        v2_q <= v1_q;
        if (v1_q) begin
          tgt_l_q <= tgt_l_d;
          tgt_r_q <= tgt_r_d;
        end
        spd_vld_q <= v2_q;
        if (v2_q) begin
          lft_q  <= slew_step(lft_q, tgt_l_q);
          rght_q <= slew_step(rght_q, tgt_r_q);
        end
        tf_q <= tf_d;
      end
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign spd_vld  = spd_vld_q;
  assign too_fast = tf_q;
  assign ss_tmr   = cnt_q[23:16];

endmodule

// File: tb/tb_balance_cntrl_slew.sv
// Directed bench for balance_cntrl_slew: a behavioural model pushes expected speeds
// into a scoreboard at each vld; a negedge monitor pops and compares on spd_vld.
module tb_balance_cntrl_slew;

  localparam int SPD_W  = 12;
  localparam int SMAX   = 2047;
  localparam int P_COEF = 9;
  localparam int SLEW   = 64;
  localparam int TF_HI  = 1536;
  localparam int TF_LO  = 1280;

  logic clk = 1'b0;
  logic rst, vld, pwr_up, rider_off, en_steer;
  logic signed [15:0] ptch, ptch_rt;
  logic [11:0] steer_pot;
  logic signed [SPD_W-1:0] lft_spd, rght_spd;
  logic spd_vld, too_fast;
  logic [7:0] ss_tmr;

  balance_cntrl_slew #(
    .FAST_SIM(1'b1), .SPD_W(SPD_W), .P_COEF(P_COEF), .SLEW(SLEW), .TF_HI(TF_HI), .TF_LO(TF_LO)
  ) dut (
    .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt), .pwr_up(pwr_up),
    .rider_off(rider_off), .steer_pot(steer_pot), .en_steer(en_steer),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld), .too_fast(too_fast),
    .ss_tmr(ss_tmr)
  );

  always #5 clk = ~clk;

  typedef struct {int l; int r; int at;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_l = 0, m_r = 0, m_integ = 0, m_ss = 0;
  bit m_tf = 1'b0, tf_pend = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x, input int lim);
    return (x > lim) ? lim : ((x < -lim) ? -lim : x);
  endfunction

  function automatic int slew_to(input int cur, input int tgt);
    if (tgt - cur > SLEW)       return cur + SLEW;
    else if (cur - tgt > SLEW)  return cur - SLEW;
    else                        return tgt;
  endfunction

  function automatic int absv(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One accepted update: model the full pitch/steer/slew chain and queue the result.
  task automatic send(input int p, input int rt);
    int err, pid, pss, st, clip, tl, tr;
    ptch = 16'(p);
    ptch_rt = 16'(rt);
    vld = 1'b1;
    err = sat(p, 511);
    if (rider_off) m_integ = 0;
    else           m_integ = sat(m_integ + err, 131071);
    pid = sat(err * P_COEF + (m_integ >>> 6) - (rt >>> 6), SMAX);
    pss = (pid * m_ss) >>> 8;
    clip = int'(steer_pot);
    if (clip < 512)  clip = 512;
    if (clip > 3584) clip = 3584;
    st = en_steer ? (((clip - 2047) * 3) >>> 4) : 0;
    tl = sat(pss + st, SMAX);
    tr = sat(pss - st, SMAX);
    m_l = slew_to(m_l, tl);
    m_r = slew_to(m_r, tr);
    sb.push_back('{m_l, m_r, cyc + 3});
    tick(1);
    vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 12) begin
      tick(1);
      n++;
    end
    check("pipeline_drained", sb.size(), 0);
    tick(1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (tf_pend) begin
      check("too_fast", too_fast, m_tf);
      tf_pend = 1'b0;
    end
    if (spd_vld === 1'b1) begin
      if (sb.size() == 0) begin
        check("spd_vld_unexpected", spd_vld, 0);
      end else begin
        e = sb.pop_front();
        check("lft_spd", lft_spd, e.l);
        check("rght_spd", rght_spd, e.r);
        check("spd_vld_cycle", cyc, e.at);
        if (absv(e.l) > TF_HI || absv(e.r) > TF_HI)        m_tf = 1'b1;
        else if (absv(e.l) <= TF_LO && absv(e.r) <= TF_LO) m_tf = 1'b0;
        tf_pend = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vld = 1'b0; pwr_up = 1'b0; rider_off = 1'b1; en_steer = 1'b0;
    ptch = '0; ptch_rt = '0; steer_pot = 12'h7FF;
    tick(3);
    check("rst_lft", lft_spd, 0);
    check("rst_rght", rght_spd, 0);
    check("rst_spd_vld", spd_vld, 0);
    check("rst_too_fast", too_fast, 0);
    check("rst_ss_tmr", ss_tmr, 0);
    rst = 1'b0;

    // Soft-start ramp and clamp
    pwr_up = 1'b1;
    tick(1);   check("ss_1", ss_tmr, 1);
    tick(99);  check("ss_100", ss_tmr, 100);
    tick(155); check("ss_255", ss_tmr, 255);
    tick(10);  check("ss_hold", ss_tmr, 255);
    m_ss = 255;

    // Proportional path with slew: 64,128,...,896 then settle
    repeat (16) send(100, 0);
    drain();
    check("p_settle_lft", lft_spd, 896);
    check("p_settle_rght", rght_spd, 896);

    // Power-down while running: immediate zero, one strobe, vld ignored
    pwr_up = 1'b0;
    sb.push_back('{0, 0, cyc + 1});
    m_l = 0; m_r = 0; m_integ = 0;
    tick(1);
    check("pd_lft", lft_spd, 0);
    check("pd_rght", rght_spd, 0);
    check("pd_too_fast", too_fast, 0);
    check("pd_ss_tmr", ss_tmr, 0);
    ptch = 16'sd200; vld = 1'b1;
    tick(3);
    vld = 1'b0;
    tick(6);
    check("pd_ss_hold", ss_tmr, 0);
    check("pd_lft_hold", lft_spd, 0);
    pwr_up = 1'b1;
    tick(256);
    check("pu_ss_255", ss_tmr, 255);

    // Steering mix at full right pot
    en_steer = 1'b1; steer_pot = 12'hFFF;
    repeat (6) send(0, 0);
    drain();
    check("steer_lft", lft_spd, 288);
    check("steer_rght", rght_spd, -288);

    // Pot change without vld is not applied
    steer_pot = 12'h000;
    tick(8);
    check("steer_hold_lft", lft_spd, 288);
    repeat (10) send(0, 0);
    drain();
    check("steer_left_lft", lft_spd, -288);
    en_steer = 1'b0; steer_pot = 12'h7FF;

    // Derivative path, floor shifts on negative values
    repeat (6) send(0, -1000);
    repeat (2) send(0, 1000);
    drain();
    check("d_lft", lft_spd, -15);

    // Integrator active, then large negative pitch saturating pid
    rider_off = 1'b0;
    m_integ = 0;
    repeat (4) send(64, 0);
    repeat (3) send(-300, 0);
    drain();
    rider_off = 1'b1;

    // too_fast hysteresis
    repeat (34) send(511, 0);
    drain();
    check("tf_set", too_fast, 1);
    repeat (20) send(0, 0);
    drain();
    check("tf_clear", too_fast, 0);

    // Reset mid-pipeline drops in-flight updates
    send(300, 0);
    send(300, 0);
    rst = 1'b1;
    sb.delete();
    m_l = 0; m_r = 0; m_integ = 0; m_tf = 1'b0; tf_pend = 1'b0;
    tick(2);
    check("mid_rst_lft", lft_spd, 0);
    check("mid_rst_rght", rght_spd, 0);
    check("mid_rst_spd_vld", spd_vld, 0);
    check("mid_rst_ss", ss_tmr, 0);
    rst = 1'b0;
    tick(5);
    check("post_rst_ss", ss_tmr, 5);
    check("post_rst_lft", lft_spd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
